// File: rtl/fifo_demux_pkg.sv
// rtl/fifo_demux_pkg.sv - shared types, defaults and destination decode for fifo_drain_demux
package fifo_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_OUT      = 2;

  // Word is zero-extended to 32 bits by the caller; the field is its top dest_w bits.
  function automatic logic [31:0] dest_of(input logic [31:0] word,
                                          input int unsigned data_width,
                                          input int unsigned dest_w);
    return (word >> (data_width - dest_w)) & ((32'd1 << dest_w) - 32'd1);
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry in-order skid queue absorbing the upstream FIFO read latency
module skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] data_in,
  input  logic         rd,
  output logic [W-1:0] head,
  output logic         head_valid,
  output logic [1:0]   occ
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({wr, rd})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = data_in;
        end else if (occ_q == 2'd1) begin
          tail_d = data_in;
        end
        if (occ_q != 2'd2) begin
          occ_d = occ_q + 2'd1;
        end
      end
      2'b01: begin
        if (occ_q != 2'd0) begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
      end
      2'b11: begin
        // Read and write together: the new word takes the freed slot, occupancy holds.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = data_in;
        end else begin
          head_d = data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head       = head_q;
  assign head_valid = (occ_q != 2'd0);
  assign occ        = occ_q;

endmodule

// File: rtl/fifo_drain_demux.sv
// rtl/fifo_drain_demux.sv - pops the shared FIFO and routes words to N_OUT destinations
// Optional per-destination and stall statistics are built when DEMUX_STATS_EN is defined.
module fifo_drain_demux
  import fifo_demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_OUT      = DEF_N_OUT,
  parameter int DEST_W     = $clog2(N_OUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic                  fifo_pop,
  input  logic [N_OUT-1:0]      dest_pause,
  output logic [N_OUT-1:0]      dest_push,
  output logic [DATA_WIDTH-1:0] dest_data,
  output logic                  busy,
  output logic                  proto_error
`ifdef DEMUX_STATS_EN
  ,
  output logic [N_OUT*16-1:0]   fwd_count,
  output logic [15:0]           stall_count
`endif
);

  logic [DATA_WIDTH-1:0] head;
  logic                  head_valid;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic [DEST_W-1:0]     head_dest;
  logic                  head_paused;
  logic                  drain;
  logic                  valid_seen;
  logic                  overflow;
  logic                  fill;
  logic                  err_now;
  logic [2:0]            demand;

  logic                  inflight_q;
  logic                  post_reset_q;
  logic                  proto_error_q;
  state_t                state_q, state_d;

  skid_buf2 #(
    .W (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .wr         (fill),
    .data_in    (fifo_data),
    .rd         (drain),
    .head       (head),
    .head_valid (head_valid),
    .occ        (occ)
  );

  assign head_dest   = DEST_W'(dest_of(32'(head), DATA_WIDTH, DEST_W));
  assign head_paused = head_valid & dest_pause[head_dest];
  assign drain       = head_valid & ~dest_pause[head_dest];
  assign dest_push   = drain ? (N_OUT'(1) << head_dest) : '0;
  assign dest_data   = head;

  // A read response landing right after reset belongs to a discarded pop.
  assign valid_seen = fifo_valid & ~post_reset_q;
  assign overflow   = valid_seen & inflight_q & (occ == 2'd2) & ~drain;
  assign fill       = valid_seen & inflight_q & ~overflow;
  assign err_now    = (valid_seen & ~inflight_q) | (inflight_q & ~fifo_valid) | overflow;

  assign demand   = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, drain};
  assign fifo_pop = ~fifo_empty & ~reset & (demand < 3'd2);
  assign occ_next = occ + {1'b0, fill} - {1'b0, drain};

  assign busy        = (occ != 2'd0) | inflight_q;
  assign proto_error = proto_error_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (head_paused) begin
          state_d = STALL;
        end else if ((occ_next == 2'd0) && !fifo_pop) begin
          state_d = IDLE;
        end
      end
      STALL: begin
        if (!head_paused) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q    <= 1'b0;
      post_reset_q  <= 1'b1;
      proto_error_q <= 1'b0;
      state_q       <= IDLE;
    end else begin
      inflight_q    <= fifo_pop;
      post_reset_q  <= 1'b0;
      proto_error_q <= proto_error_q | err_now;
      state_q       <= state_d;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [15:0] fwd_q [N_OUT];
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) begin
        fwd_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (dest_push[i] && (fwd_q[i] != 16'hFFFF)) begin
          fwd_q[i] <= fwd_q[i] + 16'd1;
        end
      end
      if ((state_q == STALL) && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  always_comb begin
    fwd_count = '0;
    for (int i = 0; i < N_OUT; i++) begin
      fwd_count[i*16 +: 16] = fwd_q[i];
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fifo_drain_demux.sv
// tb/tb_fifo_drain_demux.sv - randomized self-checking bench with a queue-based reference model
module tb_fifo_drain_demux;
  import fifo_demux_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_valid = 1'b0;
  logic       fifo_pop;
  logic [1:0] dest_pause = 2'b00;
  logic [1:0] dest_push;
  logic [7:0] dest_data;
  logic       busy;
  logic       proto_error;
`ifdef DEMUX_STATS_EN
  logic [31:0] fwd_count;
  logic [15:0] stall_count;
`endif

  fifo_drain_demux dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_valid  (fifo_valid),
    .fifo_pop    (fifo_pop),
    .dest_pause  (dest_pause),
    .dest_push   (dest_push),
    .dest_data   (dest_data),
    .busy        (busy),
    .proto_error (proto_error)
`ifdef DEMUX_STATS_EN
    ,
    .fwd_count   (fwd_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop, n_push, cyc, first_pop, first_push, last_push;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [1:0] pause_v = 2'b00;
  logic       hold_empty = 1'b0;
  logic       inject_valid = 1'b0;
  logic       chk_occ1 = 1'b0;
  logic       pop_now;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_pop = 0;
    n_push = 0;
    first_pop = -1;
    first_push = -1;
    last_push = -1;
  endtask

  // One clock: observe at the falling edge, then act as upstream FIFO and pause source.
  task automatic tick();
    logic [7:0] w;
    @(negedge clk);
    cyc++;
    pop_now = 1'b0;
    if (!reset) begin
      check_eq("outstanding_le2", 32'(exp_q.size() <= 2), 32'd1);
      if (dest_push != 2'b00) begin
        if (exp_q.size() == 0) begin
          check_eq("push_unexpected", 32'(dest_push), 32'd0);
        end else begin
          w = exp_q.pop_front();
          check_eq("push_dest", 32'(dest_push), 32'd1 << w[7]);
          check_eq("push_data", 32'(dest_data), 32'(w));
          check_eq("push_unpaused", 32'(dest_pause & dest_push), 32'd0);
          if (chk_occ1) check_eq("occ_fill_drain", 32'(dut.occ), 32'd1);
          n_push++;
          if (first_push < 0) first_push = cyc;
          last_push = cyc;
        end
      end
      if (fifo_pop) begin
        pop_now = 1'b1;
        n_pop++;
        if (first_pop < 0) first_pop = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (pop_now && (src_q.size() > 0)) begin
      fifo_valid = 1'b1;
      fifo_data  = src_q.pop_front();
      exp_q.push_back(fifo_data);
    end else begin
      fifo_valid = inject_valid;
      fifo_data  = 8'($urandom);
    end
    fifo_empty = hold_empty || (src_q.size() == 0);
    dest_pause = pause_v;
  endtask

  initial begin
    cyc = 0;
    clear_stats();

    // Reset with data available upstream
    src_q = '{8'h11, 8'h22};
    fifo_empty = 1'b0;
    tick();
    tick();
    #1;
    check_eq("rst_pop", 32'(fifo_pop), 32'd0);
    check_eq("rst_push", 32'(dest_push), 32'd0);
    check_eq("rst_err", 32'(proto_error), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_data", 32'(dest_data), 32'd0);
    check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
    src_q.delete();
    fifo_empty = 1'b1;
    reset = 1'b0;
    tick();
    tick();

    // Streaming, no pause
    clear_stats();
    src_q = '{8'h01, 8'h80, 8'h24, 8'hC3};
    fifo_empty = 1'b0;
    chk_occ1 = 1'b1;
    for (int i = 0; i < 30 && n_push < 4; i++) tick();
    chk_occ1 = 1'b0;
    check_eq("stream_count", 32'(n_push), 32'd4);
    check_eq("stream_latency", 32'(first_push - first_pop), 32'd2);
    check_eq("stream_b2b", 32'(last_push - first_push), 32'd3);
    repeat (3) tick();
    #1;
    check_eq("stream_idle_busy", 32'(busy), 32'd0);
    check_eq("stream_idle_state", 32'(dut.state_q), 32'(IDLE));
`ifdef DEMUX_STATS_EN
    check_eq("fwd_count", fwd_count, {16'd2, 16'd2});
`endif

    // Head of line blocked by a paused destination
    clear_stats();
    src_q = '{8'h80, 8'h01, 8'h24, 8'h81, 8'h03};
    pause_v = 2'b10;
    dest_pause = 2'b10;
    fifo_empty = 1'b0;
    repeat (8) tick();
    #1;
    check_eq("stall_pops", 32'(n_pop), 32'd2);
    check_eq("stall_pop_low", 32'(fifo_pop), 32'd0);
    check_eq("stall_no_push", 32'(n_push), 32'd0);
    check_eq("stall_state", 32'(dut.state_q), 32'(STALL));
    pause_v = 2'b00;
    for (int i = 0; i < 40 && n_push < 5; i++) tick();
    check_eq("stall_release_count", 32'(n_push), 32'd5);
    check_eq("stall_leftover", 32'(exp_q.size()), 32'd0);
`ifdef DEMUX_STATS_EN
    check_eq("stall_count_nz", 32'(stall_count != 16'd0), 32'd1);
`endif

    // Upstream runs dry after three words
    clear_stats();
    repeat (3) src_q.push_back(8'($urandom));
    fifo_empty = 1'b0;
    repeat (12) tick();
    #1;
    check_eq("empty_pops", 32'(n_pop), 32'd3);
    check_eq("empty_pushes", 32'(n_push), 32'd3);
    check_eq("empty_busy", 32'(busy), 32'd0);
    check_eq("empty_state", 32'(dut.state_q), 32'(IDLE));

    // Random traffic with random pauses and upstream gaps
    clear_stats();
    repeat (60) src_q.push_back(8'($urandom));
    fifo_empty = 1'b0;
    for (int i = 0; i < 3000 && n_push < 60; i++) begin
      pause_v[0] = ($urandom_range(0, 3) == 0);
      pause_v[1] = ($urandom_range(0, 3) == 0);
      hold_empty = ($urandom_range(0, 4) == 0);
      tick();
    end
    pause_v = 2'b00;
    hold_empty = 1'b0;
    check_eq("rand_count", 32'(n_push), 32'd60);
    check_eq("rand_err", 32'(proto_error), 32'd0);
    repeat (4) tick();
    #1;
    check_eq("rand_idle_busy", 32'(busy), 32'd0);

    // Spurious read-valid with no pop in flight
    inject_valid = 1'b1;
    tick();
    inject_valid = 1'b0;
    tick();
    #1;
    check_eq("proto_set", 32'(proto_error), 32'd1);
    repeat (3) tick();
    #1;
    check_eq("proto_sticky", 32'(proto_error), 32'd1);
    reset = 1'b1;
    tick();
    #1;
    check_eq("proto_cleared", 32'(proto_error), 32'd0);
    reset = 1'b0;
    fifo_valid = 1'b1;
    tick();
    tick();
    #1;
    check_eq("post_reset_valid_ignored", 32'(proto_error), 32'd0);
    check_eq("post_reset_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
